// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             we_hi;
  logic             we_lo;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, we_hi, we_lo, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, we_hi, we_lo, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// Multiply: pipelined signed/unsigned full product, latency MUL_STAGES.
// Divide: restoring magnitude division (WIDTH steps) followed by a sign
// fixup step; divide by zero resolves in a single cycle.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int LMAX = (WIDTH + 1 > MUL_STAGES) ? WIDTH + 1 : MUL_STAGES;
  localparam int CW   = $clog2(LMAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_STAGES - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DZ   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_sgn;
  logic [WIDTH-1:0] r_q, r_rem, r_dvs;
  logic             r_neg_q, r_neg_r;

  logic             w_fin, w_busy_nxt, w_start_ok;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_sh, w_diff;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic signed [WIDTH:0]       w_ma, w_mb;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]          w_mul_res;

  // New operations are only taken while nothing is in flight.
  assign w_start_ok = bus.start && (r_state == S_IDLE);
  assign w_abs_a = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_abs_b = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // One extra sign bit lets a single signed multiplier serve MULT and MULTU.
  assign w_ma   = {r_sgn & r_a[WIDTH-1], r_a};
  assign w_mb   = {r_sgn & r_b[WIDTH-1], r_b};
  assign w_prod = w_ma * w_mb;

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_sh   = {r_rem, r_q[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_dvs};

  generate
    if (MUL_STAGES > 1) begin : g_pipe
      logic [2*WIDTH-1:0] r_pipe [MUL_STAGES-1];
      // Product delay line; synthesis retimes these registers into the multiplier.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < MUL_STAGES - 1; i++) r_pipe[i] <= {(2*WIDTH){1'b0}};
        end else begin
          r_pipe[0] <= w_prod;
          for (int i = 1; i < MUL_STAGES - 1; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_mul_res = r_pipe[MUL_STAGES-2];
    end else begin : g_nopipe
      assign w_mul_res = w_prod;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, completion and busy decode.
  always_comb begin
    w_state_nxt = r_state;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op[1]) begin
            if (bus.b == ZERO) w_state_nxt = S_DZ;
            else               w_state_nxt = S_DIV;
          end else begin
            w_state_nxt = S_MUL;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (r_cnt == MUL_LAST) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_DIV: begin
        if (r_cnt == DIV_LAST) begin
          w_fin       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DIV;
        end
      end
      S_DZ: begin
        w_fin       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The capture cycle right after acceptance does not report busy.
    w_busy_nxt = (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
  end

  // Result selection for the completing operation, with divide sign fixup.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_state)
      S_MUL: begin
        w_res_hi = w_mul_res[2*WIDTH-1:WIDTH];
        w_res_lo = w_mul_res[WIDTH-1:0];
      end
      S_DIV: begin
        w_res_hi = r_neg_r ? -r_rem : r_rem;
        w_res_lo = r_neg_q ? -r_q : r_q;
      end
      S_DZ: begin
        w_res_hi = r_a;
        w_res_lo = ONES;
      end
      default: begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
      end
    endcase
  end

  // Operand capture, step counter and divider iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= {CW{1'b0}};
      r_a     <= ZERO;
      r_b     <= ZERO;
      r_sgn   <= 1'b0;
      r_q     <= ZERO;
      r_rem   <= ZERO;
      r_dvs   <= ZERO;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt   <= {CW{1'b0}};
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sgn   <= bus.op[0];
      r_q     <= w_abs_a;
      r_rem   <= ZERO;
      r_dvs   <= w_abs_b;
      r_neg_q <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_neg_r <= bus.op[0] & bus.a[WIDTH-1];
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + CNT_ONE;
      if (r_state == S_DIV && r_cnt != DIV_LAST) begin
        if (!w_diff[WIDTH]) begin
          r_rem <= w_diff[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_rem <= w_sh[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // HI/LO update: a completing result overrides any MTHI/MTLO on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= ZERO;
      r_lo   <= ZERO;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_fin;
      if (w_fin) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (!r_busy && bus.we_hi) r_hi <= bus.wd;
        if (!r_busy && bus.we_lo) r_lo <= bus.wd;
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_STAGES=2).
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus();
  muldiv_unit #(.WIDTH(32), .MUL_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;

  // Reference result {hi, lo} from plain language arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    case (op)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        p  = sa * sb;
      end
      2'd2: p = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 32'd0) begin
          p = {a, 32'hFFFFFFFF};
        end else begin
          sa = {{32{a[31]}}, a};
          sb = {{32{b[31]}}, b};
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int lat(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return 2;
    if (b == 32'd0) return 1;
    return 33;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'd0; bus.b = 32'd0;
    bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wd = 32'd0;
    #12;
    n_cmp++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: hi=%h lo=%h busy=%b done=%b, need all zero", bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation with full cycle-by-cycle busy/done and result check.
  task automatic test_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int L;
    L = lat(op, b);
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'($urandom_range(0, 3)); bus.a = $urandom; bus.b = $urandom;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s cycle0: busy=%b done=%b, need 0/0", nm, bus.busy, bus.done);
    end
    for (int k = 1; k < L; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s cycle%0d: busy=%b done=%b, need 1/0", nm, k, bus.busy, bus.done);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done cycle%0d: busy=%b done=%b, need 0/1", nm, L, bus.busy, bus.done);
    end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++;
    if ({bus.hi, bus.lo} !== exp_v) begin
      n_bad++;
      $display("FAIL %s result: hi:lo=%h, need %h", nm, {bus.hi, bus.lo}, exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || {bus.hi, bus.lo} !== exp_v) begin
      n_bad++;
      $display("FAIL %s hold: done=%b hi:lo=%h, need 0 and %h", nm, bus.done, {bus.hi, bus.lo}, exp_v);
    end
  endtask

  task automatic test_mult_back_to_back();
    exp_q.push_back(model(2'd1, 32'hFFFFFFFD, 32'h5));
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'hFFFFFFFD; bus.b = 32'h5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b first busy: busy=%b, need 1", bus.busy); end
    @(negedge clk);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++;
    if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== exp_v) begin
      n_bad++;
      $display("FAIL b2b first: done=%b hi:lo=%h, need 1 and %h", bus.done, {bus.hi, bus.lo}, exp_v);
    end
    // Next start issued in the done cycle.
    exp_q.push_back(model(2'd0, 32'd3, 32'd4));
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b second busy: busy=%b, need 1", bus.busy); end
    @(negedge clk);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++;
    if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== exp_v || exp_v !== 64'hC) begin
      n_bad++;
      $display("FAIL b2b second: done=%b hi:lo=%h, need 1 and %h", bus.done, {bus.hi, bus.lo}, 64'hC);
    end
  endtask

  task automatic test_busy_ignore();
    int k;
    logic extra;
    exp_q.push_back(model(2'd3, 32'hFFFFFFF9, 32'h2));
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'hFFFFFFF9; bus.b = 32'h2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd5; bus.b = 32'd6; bus.we_hi = 1'b1; bus.wd = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0; bus.we_hi = 1'b0;
    k = 6;
    while (bus.done !== 1'b1 && k < 45) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != 33) begin n_bad++; $display("FAIL ignore done cycle: got %0d, need 33", k); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++;
    if ({bus.hi, bus.lo} !== exp_v) begin
      n_bad++;
      $display("FAIL ignore result: hi:lo=%h, need %h", {bus.hi, bus.lo}, exp_v);
    end
    extra = 1'b0;
    repeat (4) begin @(negedge clk); if (bus.done !== 1'b0) extra = 1'b1; end
    n_cmp++;
    if (extra) begin n_bad++; $display("FAIL ignore no second done: got extra done, need none"); end
    // Idle MTLO.
    bus.we_lo = 1'b1; bus.wd = 32'hBEEF;
    @(negedge clk);
    bus.we_lo = 1'b0;
    n_cmp++;
    if (bus.lo !== 32'hBEEF || bus.hi !== exp_v[63:32] || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL mtlo: hi=%h lo=%h done=%b, need %h %h 0", bus.hi, bus.lo, bus.done, exp_v[63:32], 32'hBEEF);
    end
  endtask

  task automatic test_start_with_mt();
    int k;
    exp_q.push_back(model(2'd2, 32'd100, 32'd7));
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd100; bus.b = 32'd7; bus.we_hi = 1'b1; bus.wd = 32'h55;
    @(negedge clk);
    bus.start = 1'b0; bus.we_hi = 1'b0;
    n_cmp++;
    if (bus.hi !== 32'h55) begin n_bad++; $display("FAIL start+mthi early: hi=%h, need %h", bus.hi, 32'h55); end
    k = 0;
    while (bus.done !== 1'b1 && k < 45) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != 33) begin n_bad++; $display("FAIL start+mthi done cycle: got %0d, need 33", k); end
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    n_cmp++;
    if ({bus.hi, bus.lo} !== exp_v || exp_v !== {32'd2, 32'd14}) begin
      n_bad++;
      $display("FAIL start+mthi result: hi:lo=%h, need %h", {bus.hi, bus.lo}, {32'd2, 32'd14});
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'h12345678; bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL async reset: hi=%h lo=%h busy=%b done=%b, need zeros", bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1; end
    n_cmp++;
    if (seen || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      n_bad++;
      $display("FAIL after reset: activity=%b hi=%h lo=%h, need none and zeros", seen, bus.hi, bus.lo);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      test_op("random", op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_op("multu_max_x2", 2'd0, 32'hFFFFFFFF, 32'h2);
    test_mult_back_to_back();
    test_op("div_neg7_by2", 2'd3, 32'hFFFFFFF9, 32'h2);
    test_op("divu_100_by7", 2'd2, 32'd100, 32'd7);
    test_op("divu_by_zero", 2'd2, 32'h1234, 32'h0);
    test_op("div_by_zero", 2'd3, 32'hFFFFFFF0, 32'h0);
    test_op("div_min_by_m1", 2'd3, 32'h80000000, 32'hFFFFFFFF);
    test_op("mult_min_sq", 2'd1, 32'h80000000, 32'h80000000);
    test_busy_ignore();
    test_start_with_mt();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multiply/divide unit with architectural HI/LO registers; successor to the fixed 32-bit multiplier-plus-HI/LO arrangement in the execute stage.
- Adds signed and unsigned multiply, an iterative signed/unsigned divider, direct HI/LO writes (MTHI/MTLO), and a busy/done handshake for hazard and stall logic.
- Sits beside the ALU in the execute stage. Operands come from the execute pipeline register. hi/lo feed the MFHI/MFLO writeback mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_STAGES, 2, multiply latency in cycles (>=1). Register stages are retimed inside the multiplier.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation selected by op; sampled on the rising edge.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- we_hi  input  1  MTHI write strobe.
- we_lo  input  1  MTLO write strobe.
- wd  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  operation in flight; the pipeline stalls any MFHI/MFLO/muldiv instruction while busy=1.
- done  output  1  one-cycle pulse in the first cycle a new result is visible on hi/lo.
- hi  output  WIDTH  HI register: product upper half / remainder.
- lo  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset (async, any time, including mid-operation): hi=0, lo=0, busy=0, done=0. Any in-flight operation is aborted and nothing is written later.
- Cycle numbering: start sampled at edge 0; cycle k is the cycle after edge k.
- Acceptance:
  - start is accepted only when busy=0. start while busy=1 is ignored, with no queueing.
  - A new start may be issued in the done cycle.
- Latency L:
  - Multiply: L=MUL_STAGES.
  - Divide with b!=0: L=WIDTH+1 (WIDTH restoring iterations plus sign fixup).
  - Divide with b==0: L=1.
- Timing: busy=1 in cycles 1..L-1; busy=0 and done=1 in cycle L; hi/lo hold the new result from cycle L onward. With L=1, busy never asserts.
- Operand capture: a, b and op are captured at edge 0 and may change afterwards.
- Multiply:
  - Full 2*WIDTH product; hi=product[2W-1:W], lo=product[W-1:0].
  - MULT is two's-complement signed; MULTU is unsigned.
- Divide:
  - lo=quotient, hi=remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend. Implement as magnitude division with sign fixup.
  - DIV of the most-negative value by -1: lo=most-negative, hi=0, no trap.
  - Divide by zero (either op): lo=all ones, hi=a.
- MTHI/MTLO:
  - we_hi/we_lo are honoured only when busy=0; they are ignored while busy=1.
  - The write lands at the edge, is visible the next cycle, and does not pulse done.
  - we_hi and we_lo together write both registers.
- Simultaneous start and we_hi/we_lo while idle:
  - The MT write lands at edge 0.
  - If L=1, the result at edge 1 overwrites it. Otherwise the result overwrites it in cycle L.
- Holding: hi/lo hold their value between writes. done is low except in the result cycle.

Test Plan (WIDTH=32, MUL_STAGES=2):
- MULTU a=0xFFFFFFFF b=0x2 -> cycle 1 busy=1; cycle 2 done=1, busy=0, hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFD (-3) b=0x5 -> cycle 2 hi=0xFFFFFFFF, lo=0xFFFFFFF1. Immediate MULTU 3*4 issued in the done cycle -> two cycles later hi=0, lo=0xC.
- DIV a=0xFFFFFFF9 (-7) b=0x2 -> busy=1 in cycles 1..32; cycle 33 done=1, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU a=0x1234 b=0 -> cycle 1 done=1, busy never high, lo=0xFFFFFFFF, hi=0x1234. DIV 0x80000000 / 0xFFFFFFFF -> cycle 33 lo=0x80000000, hi=0.
- During a divide (cycle 5): start with MULTU and we_hi=1 wd=0xDEAD -> both ignored; the final hi/lo equal the divide result. While idle, we_lo=1 wd=0xBEEF -> lo=0xBEEF next cycle, done stays 0.
- rst asserted asynchronously at cycle 10 of a divide (mid-cycle) -> hi=lo=0 and busy=0 immediately; after release, no done pulse and hi/lo stay 0.
